sha256_stream_ctrl: RTL and testbench

// Bus-master sequencer that drives the sha256 core's register interface
// (cs/we/address/write_data/read_data/error) from a 32-bit word stream.

---
 rtl/sha256_pkg.sv | 45 ++++
 rtl/sha256_stream_ctrl_if.sv | 26 ++
 rtl/sha256_pad_word.sv | 24 ++
 rtl/sha256_stream_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_sha256_stream_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the sha256 stream controller: core register map,
// CTRL/STATUS bit values and the sequencer state encoding.
package sha256_pkg;

  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h20;

  localparam logic [31:0] CTRL_INIT = 32'h0000_0001;
  localparam logic [31:0] CTRL_NEXT = 32'h0000_0002;
  localparam logic [31:0] CTRL_MODE = 32'h0000_0004;

  localparam int STATUS_READY_BIT = 0;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_CTRL,
    ST_GAP,
    ST_POLL,
    ST_READ
  } state_t;

  // Where to go after a padding-phase write that leaves the word index at
  // wi_nxt. A block that cannot hold the length (extra=1) is zero-filled
  // to the end and issued; otherwise the fill stops at word 14 for the length.
  function automatic state_t fill_next(input logic [4:0] wi_nxt, input logic extra);
    state_t s;
    if (wi_nxt == 5'd16)
      s = ST_CTRL;
    else if (wi_nxt == 5'd14 && !extra)
      s = ST_LEN_HI;
    else
      s = ST_ZERO;
    return s;
  endfunction

endpackage

// File: rtl/sha256_stream_ctrl_if.sv
// Word stream input and sha256 core register bus, seen from the sequencer
// (master) and from the stream source / core side (slave).
interface sha256_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;

  logic        core_cs;
  logic        core_we;
  logic [7:0]  core_address;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_error;

  modport master (
    input  in_valid, in_data, in_last, in_nbytes, core_rdata, core_error,
    output in_ready, core_cs, core_we, core_address, core_wdata
  );

  modport slave (
    output in_valid, in_data, in_last, in_nbytes, core_rdata, core_error,
    input  in_ready, core_cs, core_we, core_address, core_wdata
  );
endinterface

// File: rtl/sha256_pad_word.sv
// Builds the BLOCK word for the final message word: keeps the valid leading
// bytes, inserts the 0x80 terminator right after them and zeroes the rest.
// A full final word leaves no room, so the terminator needs a word of its own.
module sha256_pad_word (
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] word,
  output logic        need_extra_pad
);

  // mask trailing bytes and place the 0x80 marker
  always_comb begin
    word           = data;
    need_extra_pad = 1'b0;
    case (nbytes)
      3'd0:    word = 32'h8000_0000;
      3'd1:    word = {data[31:24], 8'h80, 16'h0000};
      3'd2:    word = {data[31:16], 8'h80, 8'h00};
      3'd3:    word = {data[31:8], 8'h80};
      default: need_extra_pad = 1'b1;
    endcase
  end

endmodule

// File: rtl/sha256_stream_ctrl.sv
// Sequencer that turns a 32-bit word stream into sha256 core register
// accesses: block loads, padding, length append, INIT/NEXT, status polling
// and digest readback.
//
// state  | meaning
// IDLE   | no message; waits for the first stream word
// LOAD   | accepts stream words, each written straight to BLOCK[wi]
// PAD    | writes the 0x80000000 terminator after a full final word
// ZERO   | zero-fills block words
// LEN_HI | writes bitlen[63:32] to BLOCK14
// LEN_LO | writes bitlen[31:0] to BLOCK15
// CTRL   | issues INIT (first block) or NEXT
// GAP    | idle cycles before the first STATUS read
// POLL   | reads STATUS until ready
// READ   | reads DIGEST0..7 into digest
module sha256_stream_ctrl
  import sha256_pkg::*;
#(
  parameter bit          MODE_SHA256 = 1'b1,
  parameter int unsigned POLL_GAP    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sha256_stream_ctrl_if.master bus,
  output logic                 busy,
  output logic [255:0]         digest,
  output logic                 digest_valid,
  output logic                 err
);

  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

  state_t      state, state_nxt;
  logic [4:0]  wi;
  logic [63:0] bitlen;
  logic [15:0] gap_cnt;
  logic        first_blk;
  logic        first_word;
  logic        pad_pending;
  logic        pad_done;
  logic        need_extra;

  logic [31:0] pad_word;
  logic        pad_extra;
  logic [2:0]  last_nb;
  logic        accept;
  logic        fault;
  logic        status_ready;
  logic [31:0] ctrl_word;

  sha256_pad_word u_pad (
    .data           (bus.in_data),
    .nbytes         (bus.in_nbytes),
    .word           (pad_word),
    .need_extra_pad (pad_extra)
  );

  assign last_nb      = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
  assign accept       = (state == ST_LOAD) && bus.in_valid && !wi[4];
  assign fault        = bus.core_cs && bus.core_error;
  assign status_ready = bus.core_rdata[STATUS_READY_BIT];
  assign ctrl_word    = (first_blk ? CTRL_INIT : CTRL_NEXT) |
                        (MODE_SHA256 ? CTRL_MODE : 32'h0);
  assign busy         = (state != ST_IDLE);

  // next state and the single core access of this cycle
  always_comb begin
    state_nxt        = state;
    bus.in_ready     = 1'b0;
    bus.core_cs      = 1'b0;
    bus.core_we      = 1'b0;
    bus.core_address = 8'h00;
    bus.core_wdata   = 32'h0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.in_ready = !wi[4];
        if (accept) begin
          bus.core_cs      = 1'b1;
          bus.core_we      = 1'b1;
          bus.core_address = ADDR_BLOCK0 + {3'b000, wi};
          bus.core_wdata   = bus.in_last ? pad_word : bus.in_data;
          if (bus.in_last) begin
            if (pad_extra)
              state_nxt = (wi == 5'd15) ? ST_CTRL : ST_PAD;
            else
              state_nxt = fill_next(wi + 5'd1, wi >= 5'd14);
          end else if (wi == 5'd15) begin
            state_nxt = ST_CTRL;
          end
        end
      end
      ST_PAD: begin
        bus.core_cs      = 1'b1;
        bus.core_we      = 1'b1;
        bus.core_address = ADDR_BLOCK0 + {3'b000, wi};
        bus.core_wdata   = PAD_WORD;
        state_nxt        = fill_next(wi + 5'd1, wi >= 5'd14);
      end
      ST_ZERO: begin
        bus.core_cs      = 1'b1;
        bus.core_we      = 1'b1;
        bus.core_address = ADDR_BLOCK0 + {3'b000, wi};
        state_nxt        = fill_next(wi + 5'd1, need_extra);
      end
      ST_LEN_HI: begin
        bus.core_cs      = 1'b1;
        bus.core_we      = 1'b1;
        bus.core_address = ADDR_BLOCK0 + {3'b000, wi};
        bus.core_wdata   = bitlen[63:32];
        state_nxt        = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        bus.core_cs      = 1'b1;
        bus.core_we      = 1'b1;
        bus.core_address = ADDR_BLOCK0 + {3'b000, wi};
        bus.core_wdata   = bitlen[31:0];
        state_nxt        = ST_CTRL;
      end
      ST_CTRL: begin
        bus.core_cs      = 1'b1;
        bus.core_we      = 1'b1;
        bus.core_address = ADDR_CTRL;
        bus.core_wdata   = ctrl_word;
        state_nxt        = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == 16'd0) state_nxt = ST_POLL;
      end
      ST_POLL: begin
        bus.core_cs      = 1'b1;
        bus.core_address = ADDR_STATUS;
        if (status_ready) begin
          if (pad_pending)
            state_nxt = ST_PAD;
          else if (!pad_done)
            state_nxt = ST_LOAD;
          else if (need_extra)
            state_nxt = ST_ZERO;
          else
            state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        bus.core_cs      = 1'b1;
        bus.core_address = ADDR_DIGEST0 + {5'b00000, wi[2:0]};
        if (wi[2:0] == 3'd7) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (fault) state_nxt = ST_IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // word index, length, block flags and digest capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wi           <= 5'd0;
      bitlen       <= 64'd0;
      gap_cnt      <= 16'd0;
      first_blk    <= 1'b0;
      first_word   <= 1'b0;
      pad_pending  <= 1'b0;
      pad_done     <= 1'b0;
      need_extra   <= 1'b0;
      digest       <= 256'd0;
      digest_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      if (fault) begin
        err <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.in_valid) begin
              wi          <= 5'd0;
              bitlen      <= 64'd0;
              first_blk   <= 1'b1;
              first_word  <= 1'b1;
              pad_pending <= 1'b0;
              pad_done    <= 1'b0;
              need_extra  <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (accept) begin
              wi         <= wi + 5'd1;
              first_word <= 1'b0;
              if (first_word) err <= 1'b0;
              if (bus.in_last) begin
                bitlen <= bitlen + {58'd0, last_nb, 3'b000};
                if (pad_extra) begin
                  pad_pending <= 1'b1;
                end else begin
                  pad_done   <= 1'b1;
                  need_extra <= (wi >= 5'd14);
                end
              end else begin
                bitlen <= bitlen + 64'd32;
              end
            end
          end
          ST_PAD: begin
            wi          <= wi + 5'd1;
            pad_pending <= 1'b0;
            pad_done    <= 1'b1;
            need_extra  <= (wi >= 5'd14);
          end
          ST_ZERO, ST_LEN_HI, ST_LEN_LO: begin
            wi <= wi + 5'd1;
          end
          ST_CTRL: begin
            first_blk <= 1'b0;
            gap_cnt   <= GAP_LOAD;
          end
          ST_GAP: begin
            if (gap_cnt != 16'd0) gap_cnt <= gap_cnt - 16'd1;
          end
          ST_POLL: begin
            if (status_ready) begin
              wi <= 5'd0;
              if (!pad_pending && pad_done) need_extra <= 1'b0;
            end
          end
          ST_READ: begin
            digest <= {digest[223:0], bus.core_rdata};
            wi     <= wi + 5'd1;
            if (wi[2:0] == 3'd7) digest_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
module tb_sha256_stream_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         busy;
  logic [255:0] digest;
  logic         digest_valid;
  logic         err;

  sha256_stream_ctrl_if bus ();

  sha256_stream_ctrl #(.MODE_SHA256(1'b1), .POLL_GAP(1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.master),
    .busy         (busy),
    .digest       (digest),
    .digest_valid (digest_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- sha256 core model ----------------
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [15:0][31:0] m);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 8; i++) hv[i] = hin[(7-i)*32 +: 32];
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  logic [15:0][31:0] blk       = '0;
  logic [15:0]       blk_mask  = '0;
  int                blk_cnt   = 0;
  logic [31:0]       last_b15  = '0;
  logic [255:0]      h_state   = '0;
  int                ready_cnt = 0;
  int                n_init    = 0;
  int                n_next    = 0;
  int                proto_bad = 0;
  int                cyc       = 0;
  int                ctrl_cyc  = 0;
  bit                poll_wait = 1'b0;
  bit                clr_blk   = 1'b0;
  int                stall_cycles = 0;
  bit                inject_en   = 1'b0;
  logic [7:0]        inject_addr = 8'h00;
  logic [31:0]       hw [8];
  logic [31:0]       rdata_m;

  always_comb begin
    for (int i = 0; i < 8; i++) hw[i] = h_state[(7-i)*32 +: 32];
  end

  always_comb begin
    rdata_m = 32'h0;
    if (bus.core_address == 8'h09)
      rdata_m = {31'h0, ready_cnt == 0};
    else if (bus.core_address[7:3] == 5'b00100)
      rdata_m = hw[bus.core_address[2:0]];
  end

  assign bus.core_rdata = rdata_m;
  assign bus.core_error = inject_en && bus.core_cs && (bus.core_address == inject_addr);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (clr_blk || !reset_n) begin
      blk_cnt = 0; blk_mask = '0; poll_wait = 1'b0;
    end
    if (ready_cnt != 0) ready_cnt <= ready_cnt - 1;
    if (bus.core_cs && !bus.core_error) begin
      if (bus.core_we) begin
        if (bus.core_address[7:4] == 4'h1) begin
          blk[bus.core_address[3:0]] = bus.core_wdata;
          blk_cnt = blk_cnt + 1;
          blk_mask[bus.core_address[3:0]] = 1'b1;
          if (bus.core_address[3:0] == 4'hf) last_b15 = bus.core_wdata;
        end else if (bus.core_address == 8'h08) begin
          if (blk_cnt != 16 || blk_mask != 16'hffff) proto_bad = proto_bad + 1;
          if (!bus.core_wdata[2]) proto_bad = proto_bad + 1;
          if (bus.core_wdata[0] == bus.core_wdata[1]) proto_bad = proto_bad + 1;
          if (bus.core_wdata[0]) begin
            n_init = n_init + 1;
            h_state <= sha_compress(IV256, blk);
          end else begin
            n_next = n_next + 1;
            h_state <= sha_compress(h_state, blk);
          end
          ready_cnt <= stall_cycles;
          blk_cnt = 0; blk_mask = '0;
          ctrl_cyc = cyc; poll_wait = 1'b1;
        end else begin
          proto_bad = proto_bad + 1;
        end
      end else begin
        if (bus.core_address == 8'h09 && poll_wait) begin
          if (cyc - ctrl_cyc != 2) proto_bad = proto_bad + 1;
          poll_wait = 1'b0;
        end
        if (bus.core_address[7:4] == 4'h2 && ready_cnt != 0) proto_bad = proto_bad + 1;
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    int                nwords;
    logic [2:0]        nbytes;
    logic [15:0][31:0] words;
    logic [255:0]      exp_digest;
    int                exp_init;
    int                exp_next;
    logic [31:0]       exp_b15;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int guard;
    bit done;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.in_nbytes = nb;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      #1;
      if (bus.in_ready) done = 1'b1;
      @(negedge clk);
      guard++;
      if (!done && guard > 500) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout actual=0 expected=1");
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_digest(output bit seen, output logic busy_at);
    seen    = 1'b0;
    busy_at = 1'b1;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (digest_valid) begin
        seen    = 1'b1;
        busy_at = busy;
      end
    end
  endtask

  task automatic run_vec(input int idx, input bit gaps);
    int   i0, n0, p0;
    bit   seen;
    logic busy_at;
    clr_blk = 1'b1;
    @(negedge clk);
    clr_blk = 1'b0;
    i0 = n_init; n0 = n_next; p0 = proto_bad;
    for (int i = 0; i < vecs[idx].nwords; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      drive_word(vecs[idx].words[i], (i == vecs[idx].nwords - 1), vecs[idx].nbytes);
    end
    wait_digest(seen, busy_at);
    check($sformatf("v%0d_g%0d_digest_valid", idx, gaps), seen, 1);
    check($sformatf("v%0d_g%0d_digest", idx, gaps), digest, vecs[idx].exp_digest);
    check($sformatf("v%0d_g%0d_busy_at_valid", idx, gaps), busy_at, 0);
    check($sformatf("v%0d_g%0d_init_count", idx, gaps), n_init - i0, vecs[idx].exp_init);
    check($sformatf("v%0d_g%0d_next_count", idx, gaps), n_next - n0, vecs[idx].exp_next);
    check($sformatf("v%0d_g%0d_block_protocol", idx, gaps), proto_bad - p0, 0);
    check($sformatf("v%0d_g%0d_block15", idx, gaps), last_b15, vecs[idx].exp_b15);
    check($sformatf("v%0d_g%0d_err", idx, gaps), err, 0);
    @(negedge clk);
    check($sformatf("v%0d_g%0d_valid_pulse", idx, gaps), digest_valid, 0);
  endtask

  initial begin
    int   i0;
    bit   seen;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.in_last   = 1'b0;
    bus.in_nbytes = 3'd0;

    vecs[0].nwords = 1; vecs[0].nbytes = 3'd3; vecs[0].words = '0;
    vecs[0].words[0] = 32'h61626300;
    vecs[0].exp_digest = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    vecs[0].exp_init = 1; vecs[0].exp_next = 0; vecs[0].exp_b15 = 32'h00000018;

    vecs[1].nwords = 1; vecs[1].nbytes = 3'd0; vecs[1].words = '0;
    vecs[1].words[0] = 32'hdeadbeef;
    vecs[1].exp_digest = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    vecs[1].exp_init = 1; vecs[1].exp_next = 0; vecs[1].exp_b15 = 32'h00000000;

    vecs[2].nwords = 3; vecs[2].nbytes = 3'd2; vecs[2].words = '0;
    vecs[2].words[0] = 32'h74616e70;
    vecs[2].words[1] = 32'h68616e64;
    vecs[2].words[2] = 32'h6576ffff;
    vecs[2].exp_digest = 256'h85e9a47fc5dc216f9b3ff562488d35c93210cfd8d265688dfeb0612c56f76886;
    vecs[2].exp_init = 1; vecs[2].exp_next = 0; vecs[2].exp_b15 = 32'h00000050;

    vecs[3].nwords = 14; vecs[3].nbytes = 3'd4; vecs[3].words = '0;
    vecs[3].words[0]  = 32'h61626364; vecs[3].words[1]  = 32'h62636465;
    vecs[3].words[2]  = 32'h63646566; vecs[3].words[3]  = 32'h64656667;
    vecs[3].words[4]  = 32'h65666768; vecs[3].words[5]  = 32'h66676869;
    vecs[3].words[6]  = 32'h6768696a; vecs[3].words[7]  = 32'h68696a6b;
    vecs[3].words[8]  = 32'h696a6b6c; vecs[3].words[9]  = 32'h6a6b6c6d;
    vecs[3].words[10] = 32'h6b6c6d6e; vecs[3].words[11] = 32'h6c6d6e6f;
    vecs[3].words[12] = 32'h6d6e6f70; vecs[3].words[13] = 32'h6e6f7071;
    vecs[3].exp_digest = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    vecs[3].exp_init = 1; vecs[3].exp_next = 1; vecs[3].exp_b15 = 32'h000001c0;

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_digest", digest, 0);
    check("reset_digest_valid", digest_valid, 0);
    check("reset_err", err, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_core_cs", bus.core_cs, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int pass = 0; pass < 2; pass++) begin
      stall_cycles = (pass == 1) ? 30 : 0;
      for (int v = 0; v < 4; v++) run_vec(v, pass == 1);
    end
    stall_cycles = 0;

    // reset in the middle of a block load
    drive_word(32'h74616e70, 1'b0, 3'd0);
    drive_word(32'h68616e64, 1'b0, 3'd0);
    check("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_digest", digest, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_core_cs", bus.core_cs, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(0, 1'b0);

    // core error on the BLOCK1 write aborts the message
    i0 = n_init;
    inject_addr = 8'h11;
    inject_en   = 1'b1;
    drive_word(32'h74616e70, 1'b0, 3'd0);
    drive_word(32'h68616e64, 1'b0, 3'd0);
    inject_en = 1'b0;
    check("coreerr_err", err, 1);
    check("coreerr_busy", busy, 0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (digest_valid || bus.core_cs) seen = 1'b1;
    end
    check("coreerr_quiet", seen, 0);
    check("coreerr_no_ctrl", n_init - i0, 0);
    check("coreerr_err_sticky", err, 1);
    run_vec(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
